// File: rtl/wb_pkg.sv
// Shared types and default parameters for the writeback arbiter and its load queue.
package wb_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int ADDR_W_DEF       = 5;
  localparam int LQ_DEPTH_DEF     = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  // Queue entry at default widths; kill marks an entry superseded by a younger ALU write
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] sel;
    logic [DATA_W_DEF-1:0] data;
    logic                  kill;
  } lq_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load result queue: circular buffer with per-entry kill by destination match
// and a live-entry destination mask.
module wb_load_fifo import wb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = LQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_sel,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     push_kill,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [ADDR_W-1:0]        kill_sel,
  output logic [ADDR_W-1:0]        head_sel,
  output logic [DATA_W-1:0]        head_data,
  output logic                     head_kill,
  output logic [$clog2(DEPTH):0]   count,
  output logic [(2**ADDR_W)-1:0]   live_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data;
    logic              kill;
  } entry_t;

  entry_t            mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  assign head_sel  = mem_r[head_r].sel;
  assign head_data = mem_r[head_r].data;
  assign head_kill = mem_r[head_r].kill;
  assign count     = count_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push) tail_r <= tail_r + PTR_W'(1'b1);
      if (pop)  head_r <= head_r + PTR_W'(1'b1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; a push overrides the kill broadcast for the slot it fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{sel: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}, kill: 1'b0};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (PTR_W'(i) == tail_r)) begin
          mem_r[i] <= '{sel: push_sel, data: push_data, kill: push_kill};
        end else if (kill_en && (mem_r[i].sel == kill_sel)) begin
          mem_r[i].kill <= 1'b1;
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Destinations of occupied, non-killed slots
  always_comb begin
    live_mask = {(2**ADDR_W){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - head_r} < count_r) && !mem_r[i].kill) begin
        live_mask[mem_r[i].sel] = 1'b1;
      end else begin
        live_mask = live_mask;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the register write port first, queued loads
// drain in the gaps, and a starvation counter throttles the ALU so loads always drain.
module wb_arbiter import wb_pkg::*; #(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LQ_DEPTH       = LQ_DEPTH_DEF,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF,
  parameter bit ZERO_REG_WIRED = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_wb_valid,
  output logic                        alu_wb_ready,
  input  logic [ADDR_W-1:0]           alu_wb_sel,
  input  logic [DATA_W-1:0]           alu_wb_data,
  input  logic                        ld_wb_valid,
  output logic                        ld_wb_ready,
  input  logic [ADDR_W-1:0]           ld_wb_sel,
  input  logic [DATA_W-1:0]           ld_wb_data,
  output logic                        reg_wrt_en,
  output logic [ADDR_W-1:0]           reg_wrt_sel,
  output logic [DATA_W-1:0]           reg_wrt_data,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  output logic [(2**ADDR_W)-1:0]      ld_pend_mask
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]  LIMIT_C = ST_W'(STARVE_LIMIT);

  logic              alu_ready_r;
  logic [ST_W-1:0]   starve_r;
  logic [ST_W-1:0]   starve_nxt_s;
  logic              alu_fire_s;
  logic              ld_fire_s;
  logic              alu_zero_s;
  logic              push_kill_s;
  logic              pop_s;
  logic [ADDR_W-1:0] head_sel_s;
  logic [DATA_W-1:0] head_data_s;
  logic              head_kill_s;
  logic [CNT_W-1:0]  count_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_sel_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              wr_en_nxt_s;
  logic [ADDR_W-1:0] wr_sel_nxt_s;
  logic [DATA_W-1:0] wr_data_nxt_s;

  assign alu_wb_ready = alu_ready_r;
  assign ld_wb_ready  = (count_s < DEPTH_C);
  assign lq_count     = count_s;
  assign reg_wrt_en   = wr_en_r;
  assign reg_wrt_sel  = wr_sel_r;
  assign reg_wrt_data = wr_data_r;

  assign alu_fire_s  = alu_wb_valid & alu_ready_r;
  assign ld_fire_s   = ld_wb_valid & ld_wb_ready;
  assign alu_zero_s  = ZERO_REG_WIRED && (alu_wb_sel == {ADDR_W{1'b0}});
  // A same-cycle load is program-older than the ALU result, so it dies on a sel match
  assign push_kill_s = (ZERO_REG_WIRED && (ld_wb_sel == {ADDR_W{1'b0}})) ||
                       (alu_fire_s && (alu_wb_sel == ld_wb_sel));
  assign pop_s       = !alu_fire_s && (count_s != {CNT_W{1'b0}});

  wb_load_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (LQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ld_fire_s),
    .push_sel  (ld_wb_sel),
    .push_data (ld_wb_data),
    .push_kill (push_kill_s),
    .pop       (pop_s),
    .kill_en   (alu_fire_s),
    .kill_sel  (alu_wb_sel),
    .head_sel  (head_sel_s),
    .head_data (head_data_s),
    .head_kill (head_kill_s),
    .count     (count_s),
    .live_mask (ld_pend_mask)
  );

  // Head wait counter, saturating at the limit
  always_comb begin
    starve_nxt_s = starve_r;
    if ((count_s == {CNT_W{1'b0}}) || pop_s) begin
      starve_nxt_s = {ST_W{1'b0}};
    end else if (starve_r < LIMIT_C) begin
      starve_nxt_s = starve_r + ST_W'(1'b1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Starvation state and registered ALU ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r    <= {ST_W{1'b0}};
      alu_ready_r <= 1'b1;
    end else begin
      starve_r    <= starve_nxt_s;
      alu_ready_r <= (starve_nxt_s < LIMIT_C);
    end
  end

  // Write port selection; sel/data hold whenever no write is issued
  always_comb begin
    wr_en_nxt_s   = 1'b0;
    wr_sel_nxt_s  = wr_sel_r;
    wr_data_nxt_s = wr_data_r;
    if (alu_fire_s) begin
      wr_en_nxt_s = !alu_zero_s;
      if (!alu_zero_s) begin
        wr_sel_nxt_s  = alu_wb_sel;
        wr_data_nxt_s = alu_wb_data;
      end else begin
        wr_sel_nxt_s  = wr_sel_r;
      end
    end else if (pop_s) begin
      wr_en_nxt_s = !head_kill_s;
      if (!head_kill_s) begin
        wr_sel_nxt_s  = head_sel_s;
        wr_data_nxt_s = head_data_s;
      end else begin
        wr_sel_nxt_s  = wr_sel_r;
      end
    end else begin
      wr_en_nxt_s = 1'b0;
    end
  end

  // Register file write port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_sel_r  <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      wr_en_r   <= wr_en_nxt_s;
      wr_sel_r  <= wr_sel_nxt_s;
      wr_data_r <= wr_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter plus sequences for starvation and reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_sel;
  logic [31:0] alu_wb_data;
  logic        ld_wb_valid, ld_wb_ready;
  logic [4:0]  ld_wb_sel;
  logic [31:0] ld_wb_data;
  logic        reg_wrt_en;
  logic [4:0]  reg_wrt_sel;
  logic [31:0] reg_wrt_data;
  logic [2:0]  lq_count;
  logic [31:0] ld_pend_mask;

  int tests = 0;
  int fails = 0;

  wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_sel   (alu_wb_sel),
    .alu_wb_data  (alu_wb_data),
    .ld_wb_valid  (ld_wb_valid),
    .ld_wb_ready  (ld_wb_ready),
    .ld_wb_sel    (ld_wb_sel),
    .ld_wb_data   (ld_wb_data),
    .reg_wrt_en   (reg_wrt_en),
    .reg_wrt_sel  (reg_wrt_sel),
    .reg_wrt_data (reg_wrt_data),
    .lq_count     (lq_count),
    .ld_pend_mask (ld_pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  asel;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lsel;
    logic [31:0] ldat;
    logic        e_ar;
    logic        e_lr;
    logic        e_en;
    logic [4:0]  e_sel;
    logic [31:0] e_dat;
    logic [2:0]  e_cnt;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] asel, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lsel, input logic [31:0] ldat);
    alu_wb_valid = av;
    alu_wb_sel   = asel;
    alu_wb_data  = adat;
    ld_wb_valid  = lv;
    ld_wb_sel    = lsel;
    ld_wb_data   = ldat;
  endtask

  task automatic chk_post(input string tag, input logic en, input logic [4:0] sel,
                          input logic [31:0] dat, input logic [2:0] cnt, input logic [31:0] mask);
    chk({tag, "_en"},   {63'd0, reg_wrt_en}, {63'd0, en});
    chk({tag, "_sel"},  {59'd0, reg_wrt_sel}, {59'd0, sel});
    chk({tag, "_data"}, {32'd0, reg_wrt_data}, {32'd0, dat});
    chk({tag, "_cnt"},  {61'd0, lq_count}, {61'd0, cnt});
    chk({tag, "_mask"}, {32'd0, ld_pend_mask}, {32'd0, mask});
  endtask

  initial begin
    logic [31:0] m;
    //            av    asel   adat          lv    lsel   ldat    ear   elr   en    sel    dat           cnt   mask
    vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 3'd0, 32'h0};
    vecs[1]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 3'd0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 3'd0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h11, 1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 3'd1, 32'h20};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h22, 1'b1, 1'b1, 1'b1, 5'd5, 32'h11,       3'd1, 32'h40};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd6, 32'h22,       3'd0, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd6, 32'h22,       3'd0, 32'h0};
    vecs[7]  = '{1'b1, 5'd1, 32'h100,      1'b1, 5'd7, 32'hAA, 1'b1, 1'b1, 1'b1, 5'd1, 32'h100,      3'd1, 32'h80};
    vecs[8]  = '{1'b1, 5'd2, 32'h200,      1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd2, 32'h200,      3'd1, 32'h80};
    vecs[9]  = '{1'b1, 5'd7, 32'hBB,       1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'hBB,       3'd1, 32'h0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd7, 32'hBB,       3'd0, 32'h0};
    vecs[11] = '{1'b1, 5'd9, 32'h1,        1'b1, 5'd9, 32'h2,  1'b1, 1'b1, 1'b1, 5'd9, 32'h1,        3'd1, 32'h0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd9, 32'h1,        3'd0, 32'h0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b1, 1'b1, 1'b0, 5'd9, 32'h1,        3'd1, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd9, 32'h1,        3'd0, 32'h0};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    chk_post("reset", 1'b0, 5'd0, 32'h0, 3'd0, 32'h0);
    chk("reset_alu_ready", {63'd0, alu_wb_ready}, 64'd1);
    chk("reset_ld_ready",  {63'd0, ld_wb_ready},  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // One row per cycle: readiness before the edge, write port and queue state after it
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].av, vecs[i].asel, vecs[i].adat, vecs[i].lv, vecs[i].lsel, vecs[i].ldat);
      @(negedge clk);
      chk($sformatf("row%0d_alu_ready", i), {63'd0, alu_wb_ready}, {63'd0, vecs[i].e_ar});
      chk($sformatf("row%0d_ld_ready", i),  {63'd0, ld_wb_ready},  {63'd0, vecs[i].e_lr});
      @(posedge clk); #1;
      chk_post($sformatf("row%0d", i), vecs[i].e_en, vecs[i].e_sel, vecs[i].e_dat,
               vecs[i].e_cnt, vecs[i].e_mask);
    end

    // Full queue and starvation: ALU valid every cycle, four loads pushed up front
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'(10 + k), 32'h100 + k, (k < 4), 5'(20 + k), 32'h500 + k);
      @(negedge clk);
      chk($sformatf("starve%0d_alu_ready", k), {63'd0, alu_wb_ready}, {63'd0, (k < 9)});
      chk($sformatf("starve%0d_ld_ready", k),  {63'd0, ld_wb_ready},  {63'd0, (k < 4)});
      @(posedge clk); #1;
      m = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (b <= k && !(k == 9 && b == 0)) m[20 + b] = 1'b1;
      end
      if (k < 9) begin
        chk_post($sformatf("starve%0d", k), 1'b1, 5'(10 + k), 32'h100 + k,
                 (k < 4) ? 3'(k + 1) : 3'd4, m);
      end else begin
        chk_post($sformatf("starve%0d", k), 1'b1, 5'd20, 32'h500, 3'd3, m);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_alu_ready", j), {63'd0, alu_wb_ready}, 64'd1);
      chk($sformatf("drain%0d_ld_ready", j),  {63'd0, ld_wb_ready},  64'd1);
      @(posedge clk); #1;
      m = 32'h0;
      for (int b = j + 1; b < 4; b++) m[20 + b] = 1'b1;
      chk_post($sformatf("drain%0d", j), 1'b1, 5'(20 + j), 32'h500 + j, 3'(3 - j), m);
    end

    // Reset with three live entries queued behind a busy ALU
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd1, 32'h40 + k, 1'b1, 5'(25 + k), 32'h60 + k);
      @(posedge clk); #1;
    end
    chk("prereset_cnt", {61'd0, lq_count}, 64'd3);
    chk("prereset_mask", {32'd0, ld_pend_mask}, 64'h0E00_0000);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_post("midreset", 1'b0, 5'd0, 32'h0, 3'd0, 32'h0);
    chk("midreset_alu_ready", {63'd0, alu_wb_ready}, 64'd1);
    chk("midreset_ld_ready",  {63'd0, ld_wb_ready},  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_post($sformatf("postreset%0d", k), 1'b0, 5'd0, 32'h0, 3'd0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the bypassing register file and owns its single write port (`reg_wrt_en/sel/data`). It merges two result sources: the single-cycle ALU pipeline, which has priority, and the variable-latency load unit, whose results queue in a small FIFO. It preserves last-writer-wins ordering per register and exports a pending-load mask for the hazard unit. A starvation counter throttles the ALU so that queued loads always drain.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register select width
- `LQ_DEPTH`, 4, load queue entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, cycles a non-empty queue head may wait before the ALU is throttled
- `ZERO_REG_WIRED`, 1, when 1 writes to register 0 are suppressed

Ports (one clock `clk`; reset `rst_n` asynchronous, active-low):
- `clk  in  1  clock`
- `rst_n  in  1  async active-low reset`
- `alu_wb_valid  in  1  ALU result present`
- `alu_wb_ready  out  1  ALU result accepted this cycle when high with valid`
- `alu_wb_sel  in  ADDR_W  ALU destination register`
- `alu_wb_data  in  DATA_W  ALU result`
- `ld_wb_valid  in  1  load result present`
- `ld_wb_ready  out  1  queue can accept`
- `ld_wb_sel  in  ADDR_W  load destination`
- `ld_wb_data  in  DATA_W  load data`
- `reg_wrt_en  out  1  register file write enable (registered)`
- `reg_wrt_sel  out  ADDR_W  register file write select (registered)`
- `reg_wrt_data  out  DATA_W  register file write data (registered)`
- `lq_count  out  $clog2(LQ_DEPTH)+1  queue occupancy`
- `ld_pend_mask  out  2**ADDR_W  bit r set when a live (non-killed) queued entry targets register r`

## Operation
- ALU accept: `alu_fire = alu_wb_valid & alu_wb_ready`. A fire issues a write next cycle. If `ZERO_REG_WIRED` is set and sel is 0, the fire is accepted but `reg_wrt_en` stays 0.
- Load accept: `ld_fire = ld_wb_valid & ld_wb_ready`, with `ld_wb_ready = (lq_count < LQ_DEPTH)`. The entry is pushed as {sel, data, kill}. `kill` is set at push if sel is 0 (when `ZERO_REG_WIRED`), or if `alu_fire` occurs the same cycle to the same sel. A same-cycle load is defined as program-older than the ALU result.
- Ordering: on every `alu_fire`, all queued entries with a matching sel get `kill` set. Arrival order equals program order per destination, and upstream guarantees this.
- Drain: when there is no `alu_fire` and the queue is non-empty, pop the head.
  - If head `kill`=0, write it next cycle.
  - If head `kill`=1, pop with `reg_wrt_en`=0.
- Starvation: `starve_cnt` increments each cycle the queue is non-empty and the head is not popped. It clears on any pop or when the queue is empty.
  - When `starve_cnt` reaches `STARVE_LIMIT`, `alu_wb_ready` drops (registered) and stays low until the head pops.
  - Otherwise `alu_wb_ready`=1.
- `ld_pend_mask` is the OR of the one-hot sel of all live entries. It updates the same cycle as push/kill/pop, so it is combinational from queue state.
- Push and pop in the same cycle are allowed; the count is unchanged.
- A push while full cannot occur because ready is low. Valid-without-ready holds data stable (upstream obligation).

## Timing
- Latency: input fire/pop at edge N → `reg_wrt_*` valid in cycle N+1. The write commits at edge N+1, and the regfile bypass covers readers in cycle N+1.
- At most one register write per cycle.
- `reg_wrt_sel`/`reg_wrt_data` hold their last value when `reg_wrt_en`=0.
- Reset values: `reg_wrt_en`=0, `reg_wrt_sel`=0, `reg_wrt_data`=0, `alu_wb_ready`=1, `ld_wb_ready`=1, `lq_count`=0, `ld_pend_mask`=0, `starve_cnt`=0.
- Reset mid-operation discards all queued entries without writing them.
- Worst-case head wait is `STARVE_LIMIT`+1 cycles.

## Structure
- Package `wb_pkg`: `lq_entry_t` struct {sel, data, kill} and the default parameter constants.
- Sub-module `wb_load_fifo`: circular buffer with head/tail pointers, count, per-entry kill update port (sel match), and live-mask generation.
- The arbiter, starvation counter and output registers live in `wb_arbiter`.

## Test plan
- ALU only: a fire of sel=3, data=0xDEAD_BEEF at cycle 1 → `reg_wrt_en`=1, sel=3, data=0xDEADBEEF in cycle 2. A fire of sel=0 → `reg_wrt_en`=0.
- Load drain: with ALU idle, push loads (5, 0x11) and (6, 0x22) in consecutive cycles → writes of 5/0x11 and then 6/0x22 in the next two cycles; `ld_pend_mask` bits 5 and 6 clear as each pops.
- Kill: queue load (7, 0xAA) while the ALU fires every cycle, then an ALU fire to 7 with 0xBB → the final value written to 7 is 0xBB. The load pops later with `reg_wrt_en`=0, and `ld_pend_mask[7]` clears at the ALU fire.
- Same-cycle collision: an ALU fire (9, 0x1) and a load push (9, 0x2) in the same cycle → only 9/0x1 is written; the entry pops killed.
- Full/starvation: hold the ALU valid continuously and push 4 loads → `ld_wb_ready`=0 at count 4. After 8 waiting cycles `alu_wb_ready`=0, the head drains, and ready returns to 1 after the pop.
- Reset mid-queue: with 3 entries queued, pulse `rst_n` low asynchronously → outputs go to reset values immediately, and no stale write appears after release.
